// File: rtl/dec_pkg.sv
// dec_pkg: shared constants, the pipeline entry type and a saturating
// counter helper for the write-select decoder pipeline (dec_wr_pipe).
package dec_pkg;

  localparam int unsigned DEC_ADDR_W_DEF = 3;
  localparam int unsigned DEC_CNT_W      = 8;

  // One pipeline entry at the default address width.
  typedef struct packed {
    logic                            valid;
    logic [DEC_ADDR_W_DEF-1:0]       addr;
    logic [(2**DEC_ADDR_W_DEF)-1:0]  sel;
  } dec_entry_t;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [DEC_CNT_W-1:0] dec_sat_inc(input logic [DEC_CNT_W-1:0] v);
    return (v == '1) ? v : v + DEC_CNT_W'(1);
  endfunction

endpackage

// File: rtl/dec_stage.sv
// dec_stage: one valid/ready register slice.
//   clk, reset       rising-edge clock, synchronous active-high reset
//   flush            clears the held valid bit on the next edge
//   in_valid/ready   upstream handshake, in_data payload
//   out_valid/ready  downstream handshake, out_data payload
// The slice loads whenever it is empty or its content is leaving, so
// in_ready depends only on local state and out_ready, never on in_valid.
module dec_stage #(
  parameter int unsigned W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end

endmodule

// File: rtl/dec_wr_pipe.sv
// dec_wr_pipe: decodes a write address/enable pair into a one-hot register
// write select and carries it through STAGES (1 or 2) valid/ready slices.
//   clk, reset          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_addr, in_wen are the payload
//   flush               discards every in-flight entry and the input offered
//   out_valid/out_ready output handshake
//   out_sel             one-hot write select, zero when out_valid=0
//   out_addr            registered copy of the address
//   drop_cnt            saturating count of suppressed zero-register writes
//   sel_err             (only with DEC_ONEHOT_CHK_EN defined) sticky flag set
//                       when out_sel is not a legal one-hot of out_addr
// Parameters: ADDR_W address width, STAGES register depth (1 or 2),
// ZERO_EN makes index 2**ADDR_W-1 a hardwired-zero register.
module dec_wr_pipe
  import dec_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEC_ADDR_W_DEF,
  parameter int unsigned STAGES  = 1,
  parameter int unsigned ZERO_EN = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      in_addr,
  input  logic                   in_wen,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [(2**ADDR_W)-1:0] out_sel,
  output logic [ADDR_W-1:0]      out_addr,
  output logic [DEC_CNT_W-1:0]   drop_cnt
`ifdef DEC_ONEHOT_CHK_EN
  ,
  output logic                   sel_err
`endif
);

  localparam int unsigned N = 2**ADDR_W;
  localparam int unsigned W = ADDR_W + N;

  logic         is_zero_reg;
  logic [N-1:0] dec_sel;
  logic [W-1:0] entry_in;
  logic         last_valid;
  logic [W-1:0] last_data;

  assign is_zero_reg = (ZERO_EN != 0) && (in_addr == '1);

  always_comb begin
    dec_sel = '0;
    if (in_wen && !is_zero_reg) begin
      dec_sel[in_addr] = 1'b1;
    end
  end

  assign entry_in = {in_addr, dec_sel};

  // Separate per-depth chains keep the ready path free of a self-referencing
  // vector, which a shared array indexed by stage would create.
  if (STAGES == 1) begin : g_one
    dec_stage #(.W(W)) u_s0 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (entry_in),
      .out_valid (last_valid),
      .out_ready (out_ready),
      .out_data  (last_data)
    );
  end else begin : g_two
    logic         mid_valid;
    logic         mid_ready;
    logic [W-1:0] mid_data;

    dec_stage #(.W(W)) u_s0 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (entry_in),
      .out_valid (mid_valid),
      .out_ready (mid_ready),
      .out_data  (mid_data)
    );

    dec_stage #(.W(W)) u_s1 (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (mid_valid),
      .in_ready  (mid_ready),
      .in_data   (mid_data),
      .out_valid (last_valid),
      .out_ready (out_ready),
      .out_data  (last_data)
    );
  end

  assign out_valid = last_valid;
  assign out_sel   = last_valid ? last_data[N-1:0] : '0;
  assign out_addr  = last_data[W-1:N];

  // A write offered together with flush is discarded, so it is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
    end else if (!flush && in_valid && in_ready && in_wen && is_zero_reg) begin
      drop_cnt <= dec_sat_inc(drop_cnt);
    end
  end

`ifdef DEC_ONEHOT_CHK_EN
  logic sel_bad;

  assign sel_bad = ($countones(out_sel) > 1) ||
                   ((out_sel != '0) && (out_sel != (N'(1) << out_addr)));

  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (sel_bad) begin
      sel_err <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/dec_wr_pipe.md
DEC_WR_PIPE -- requirements
Module: dec_wr_pipe

Interface
REQ-001 Parameter ADDR_W, default 3: address width; the output is 2**ADDR_W one-hot lines.
REQ-002 Parameter STAGES, default 1: number of pipeline register stages; legal values are 1 and 2.
REQ-003 Parameter ZERO_EN, default 0: when 1, index 2**ADDR_W-1 is the hardwired-zero register and writes to it are suppressed.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 Port clk, input, 1: rising-edge clock.
REQ-006 Port reset, input, 1: synchronous, active-high reset.
REQ-007 Port in_valid, input, 1: the address/enable pair is offered.
REQ-008 Port in_ready, output, 1: the block accepts the pair this cycle.
REQ-009 Port in_addr, input, ADDR_W: write address.
REQ-010 Port in_wen, input, 1: write enable.
REQ-011 Port flush, input, 1: discard all in-flight entries.
REQ-012 Port out_valid, output, 1: out_sel and out_addr are valid.
REQ-013 Port out_ready, input, 1: the consumer accepts the entry.
REQ-014 Port out_sel, output, 2**ADDR_W: one-hot write select; all zero when out_valid=0.
REQ-015 Port out_addr, output, ADDR_W: registered copy of the address.
REQ-016 Port drop_cnt, output, 8: saturating count of suppressed zero-register writes.

Function
REQ-017 A transfer SHALL occur on a cycle where in_valid && in_ready; the entry then appears at the output after exactly STAGES cycles when the pipeline is not stalled.
REQ-018 The decode SHALL be out_sel[i] = wen && (addr == i), computed before the first register, so out_sel holds at most one set bit.
REQ-019 Each stage SHALL hold a valid bit and SHALL advance when the downstream stage is empty or is itself advancing.
REQ-020 in_ready SHALL equal !stage0_valid || stage0_advance, with no combinational path from in_valid to in_ready.
REQ-021 While out_valid && !out_ready, all stage contents SHALL hold stable.
REQ-022 When ZERO_EN=1 and a write is accepted with in_wen=1 and in_addr=2**ADDR_W-1:
- the entry SHALL pass with out_sel all zero;
- drop_cnt SHALL increment, saturating at 255.
REQ-023 An entry with in_wen=0 SHALL pass through with out_sel all zero, and out_valid SHALL still assert for it.
REQ-024 When flush=1, all stage valid bits SHALL clear on the next edge, and an input arriving in the same cycle SHALL be discarded; in_ready is unaffected.
REQ-025 If flush and reset are both asserted, reset SHALL take priority.
REQ-026 drop_cnt SHALL not change on flush.

Reset
REQ-027 On reset:
- out_valid=0, out_sel=0, out_addr=0, drop_cnt=0;
- all stage valid bits=0;
- in_ready=1 on the first cycle after reset deasserts.
REQ-028 Reset asserted mid-transfer SHALL discard all in-flight entries without producing output.

Configuration
REQ-029 Macro DEC_ONEHOT_CHK_EN, when defined:
- adds output port sel_err (1 bit);
- sel_err is sticky and set when the output stage holds more than one set bit in out_sel, or holds a non-zero out_sel whose index differs from out_addr;
- sel_err is cleared only by reset.
REQ-030 When DEC_ONEHOT_CHK_EN is undefined, the port and its logic SHALL be absent, and behaviour SHALL otherwise be identical.

Structure
REQ-031 Package dec_pkg SHALL hold:
- DEC_ADDR_W_DEF = 3;
- DEC_CNT_W = 8;
- typedef dec_entry_t (valid, addr, sel).
REQ-032 A sub-module dec_stage SHALL implement one valid/ready register slice and be instantiated STAGES times.

Verification
REQ-033 Reset, then in_addr=3'd5, in_wen=1, in_valid=1, out_ready=1 -> 1 cycle later out_valid=1, out_sel=8'h20, out_addr=5.
REQ-034 STAGES=2, send addresses 0..7 back-to-back with out_ready=1 -> out_sel sequence 01, 02, 04 ... 80, starting 2 cycles after the first input, with no bubbles.
REQ-035 ZERO_EN=1, send addr=7 with wen=1 three times -> out_sel=0 each time and drop_cnt=3.
REQ-036 Hold out_ready=0 for 4 cycles with STAGES=1 and a valid entry held -> in_ready=0 and out_sel stable; on release the entry drains once.
REQ-037 flush asserted while 2 entries are in flight (STAGES=2) -> out_valid=0 next cycle, and neither entry emerges.
REQ-038 With DEC_ONEHOT_CHK_EN defined, force the output register to 8'h21 -> sel_err=1 next cycle, and it stays 1 until reset.
